// File: rtl/quadrature_gen.sv
//-----------------------------------------------------------------------------
// quadrature_gen
//
// Purpose:
//   Emits a programmable burst of quadrature transitions on enc_a/enc_b.
//   A command (direction + transition count) is accepted while idle. Each
//   transition is followed by a hold of PHASE_CYCLES clocks, during which the
//   (a,b) state stays stable. A signed running position follows every
//   transition. After the last transition the block waits one full hold
//   before it reports ready again.
//
// Ports:
//   clk        in   1  sole clock, rising edge
//   reset      in   1  synchronous, active-low reset
//   cmd_valid  in   1  step command offered
//   cmd_dir    in   1  1 = forward (A leads B), 0 = reverse (B leads A)
//   cmd_count  in   8  number of transitions to emit (0 = no-op)
//   cmd_ready  out  1  block can accept a command (state is IDLE)
//   enc_a      out  1  quadrature channel A, registered
//   enc_b      out  1  quadrature channel B, registered
//   busy       out  1  command in progress (inverse of cmd_ready)
//   position   out  8  net transitions emitted since reset, mod 256
//
// Parameters:
//   PHASE_CYCLES  clocks between consecutive transitions (2..255; 8..255
//                 when bounce emulation is enabled)
//
// Build option:
//   QUADRATURE_GEN_BOUNCE_EN  when defined, the line that changes on each
//                             transition follows new,old,new,old,new over
//                             five clocks before settling (contact bounce
//                             emulation). Position still counts once.
//-----------------------------------------------------------------------------
module quadrature_gen #(
    parameter int PHASE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_count,
    output logic       cmd_ready,
    output logic       enc_a,
    output logic       enc_b,
    output logic       busy,
    output logic [7:0] position
);

    localparam int CW = $clog2(PHASE_CYCLES + 1);

    // Hold counter value on the last held cycle before the idle return,
    // and on the cycle before a follow-on STEP (STEP itself is the final
    // held cycle of that phase).
    localparam logic [CW-1:0] HOLD_LAST = CW'(PHASE_CYCLES);
    localparam logic [CW-1:0] HOLD_PRE  = CW'(PHASE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Next quadrature state, ab = {a, b}.
    // Forward 00->10->11->01->00 : a' = ~b, b' = a
    // Reverse 00->01->11->10->00 : a' =  b, b' = ~a
    function automatic logic [1:0] quad_next(input logic [1:0] ab, input logic fwd);
        logic [1:0] nxt;
        if (fwd) begin
            nxt = {~ab[0], ab[1]};
        end else begin
            nxt = {ab[0], ~ab[1]};
        end
        return nxt;
    endfunction

    state_e        state_q, state_d;
    logic [1:0]    ab_q, ab_d;
    logic [7:0]    pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rem_q, rem_d;
    logic          dir_q, dir_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    // Next-state and datapath: command capture, transition emission, hold timing.
    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dir_d   = dir_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d = cmd_dir;
                    rem_d = cmd_count;
                    // A zero-length command is accepted but leaves us idle.
                    if (cmd_count != 8'd0) begin
                        state_d = STEP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            STEP: begin
                // The transition lands on the edge that leaves STEP.
                ab_d    = quad_next(ab_q, dir_q);
                if (dir_q) begin
                    pos_d = pos_q + 8'd1;
                end else begin
                    pos_d = pos_q - 8'd1;
                end
                rem_d   = rem_q - 8'd1;
                cnt_d   = CNT_ONE;
                state_d = HOLD;
            end

            HOLD: begin
                if ((rem_q != 8'd0) && (cnt_q == HOLD_PRE)) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = STEP;
                end else if ((rem_q == 8'd0) && (cnt_q == HOLD_LAST)) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = HOLD;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                rem_d   = 8'd0;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ab_q    <= 2'b00;
            pos_q   <= 8'd0;
            cnt_q   <= CNT_ZERO;
            rem_q   <= 8'd0;
            dir_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign position  = pos_q;

`ifdef QUADRATURE_GEN_BOUNCE_EN
    // Bounce emulation: ab_q is the clean logical state; enc_q is what the
    // outside world sees. bph_q walks 1..4 through the four post-edge
    // cycles; odd phases show the old level on the changed line.
    logic       step_s;
    logic [2:0] bph_q, bph_d;
    logic [1:0] chg_q, chg_d;
    logic [1:0] enc_q, enc_d;

    assign step_s = (state_q == STEP);

    // Bounce pattern sequencing for the changed line.
    always_comb begin
        bph_d = bph_q;
        chg_d = chg_q;
        enc_d = ab_q;
        if (step_s) begin
            enc_d = ab_d;
            chg_d = ab_d ^ ab_q;
            bph_d = 3'd1;
        end else if (bph_q != 3'd0) begin
            if (bph_q[0]) begin
                enc_d = ab_q ^ chg_q;
            end else begin
                enc_d = ab_q;
            end
            if (bph_q == 3'd4) begin
                bph_d = 3'd0;
            end else begin
                bph_d = bph_q + 3'd1;
            end
        end else begin
            enc_d = ab_q;
        end
    end

    // Bounce output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bph_q <= 3'd0;
            chg_q <= 2'b00;
            enc_q <= 2'b00;
        end else begin
            bph_q <= bph_d;
            chg_q <= chg_d;
            enc_q <= enc_d;
        end
    end

    assign enc_a = enc_q[1];
    assign enc_b = enc_q[0];
`else
    assign enc_a = ab_q[1];
    assign enc_b = ab_q[0];
`endif

endmodule

// File: tb/tb_quadrature_gen.sv
module tb_quadrature_gen;

    localparam int PC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [7:0] cmd_count;
    logic       cmd_ready;
    logic       enc_a;
    logic       enc_b;
    logic       busy;
    logic [7:0] position;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    quadrature_gen #(.PHASE_CYCLES(PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .cmd_ready (cmd_ready),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .busy      (busy),
        .position  (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             dir;
        logic [7:0]       cnt;
        logic [1:0]       prev_ab;
        logic [7:0]       prev_pos;
        logic [0:3][1:0]  seq;
        logic [0:3][7:0]  pos;
    } vec_t;

    vec_t vec [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst_ab",    32'({enc_a, enc_b}), 32'd0);
        chk("rst_pos",   32'(position),       32'd0);
        chk("rst_ready", 32'(cmd_ready),      32'd1);
        chk("rst_busy",  32'(busy),           32'd0);
        reset = 1'b1;
    endtask

    // Waits (bounded) for ready, then presents the command for one edge.
    // On return cyc==0 denotes the cycle just after the accepting edge.
    task automatic issue(input logic dir, input logic [7:0] cnt);
        int w = 0;
        while (!cmd_ready && w < 200) begin
            tick();
            w++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 32'(cmd_ready), 32'd1);
        end
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = cnt;
        tick();
        cyc       = 0;
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        if (v.rst) begin
            do_reset();
        end
        chk("pre_ab",  32'({enc_a, enc_b}), 32'(v.prev_ab));
        chk("pre_pos", 32'(position),       32'(v.prev_pos));
        issue(v.dir, v.cnt);
        if (v.cnt == 8'd0) begin
            chk("zero_ready0", 32'(cmd_ready), 32'd1);
            repeat (20) tick();
            chk("zero_ab",    32'({enc_a, enc_b}), 32'(v.prev_ab));
            chk("zero_pos",   32'(position),       32'(v.prev_pos));
            chk("zero_ready", 32'(cmd_ready),      32'd1);
        end else begin
            for (int k = 0; k < int'(v.cnt); k++) begin
                t = 1 + k * PC;
                while (cyc < t - 1) tick();
                chk("hold_ab", 32'({enc_a, enc_b}), (k == 0) ? 32'(v.prev_ab) : 32'(v.seq[k-1]));
                tick();
                chk("step_ab",   32'({enc_a, enc_b}), 32'(v.seq[k]));
                chk("step_pos",  32'(position),       32'(v.pos[k]));
                chk("step_busy", 32'(busy),           32'd1);
            end
            t = 1 + (int'(v.cnt) - 1) * PC;
            while (cyc < t + PC - 1) tick();
            chk("tail_ready_lo", 32'(cmd_ready), 32'd0);
            tick();
            chk("tail_ready_hi", 32'(cmd_ready), 32'd1);
            chk("tail_busy",     32'(busy),      32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = 8'd0;

        // rst, dir, cnt, prev_ab, prev_pos, transitions, positions
        vec[0] = '{1'b1, 1'b1, 8'd4, 2'b00, 8'd0,
                   {2'b10, 2'b11, 2'b01, 2'b00}, {8'd1, 8'd2, 8'd3, 8'd4}};
        vec[1] = '{1'b1, 1'b0, 8'd1, 2'b00, 8'd0,
                   {2'b01, 2'b00, 2'b00, 2'b00}, {8'd255, 8'd0, 8'd0, 8'd0}};
        vec[2] = '{1'b1, 1'b1, 8'd2, 2'b00, 8'd0,
                   {2'b10, 2'b11, 2'b00, 2'b00}, {8'd1, 8'd2, 8'd0, 8'd0}};
        vec[3] = '{1'b0, 1'b0, 8'd2, 2'b11, 8'd2,
                   {2'b10, 2'b00, 2'b00, 2'b00}, {8'd1, 8'd0, 8'd0, 8'd0}};
        vec[4] = '{1'b0, 1'b1, 8'd0, 2'b00, 8'd0,
                   {2'b00, 2'b00, 2'b00, 2'b00}, {8'd0, 8'd0, 8'd0, 8'd0}};
        vec[5] = '{1'b0, 1'b0, 8'd3, 2'b00, 8'd0,
                   {2'b01, 2'b11, 2'b10, 2'b00}, {8'd255, 8'd254, 8'd253, 8'd0}};
        vec[6] = '{1'b0, 1'b1, 8'd3, 2'b10, 8'd253,
                   {2'b11, 2'b01, 2'b00, 2'b00}, {8'd254, 8'd255, 8'd0, 8'd0}};

        for (int i = 0; i < 7; i++) begin
            run_vec(vec[i]);
        end

        // Command offered while busy is ignored; reset in the 3rd hold aborts.
        do_reset();
        issue(1'b1, 8'd8);
        while (cyc < 5) tick();
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_count = 8'd5;
        tick();
        cmd_valid = 1'b0;
        while (cyc < 40) tick();
        chk("abort_pre_ab",  32'({enc_a, enc_b}), 32'h1);
        chk("abort_pre_pos", 32'(position),       32'd3);
        reset = 1'b0;
        tick();
        chk("abort_ab",    32'({enc_a, enc_b}), 32'd0);
        chk("abort_pos",   32'(position),       32'd0);
        chk("abort_ready", 32'(cmd_ready),      32'd1);
        chk("abort_busy",  32'(busy),           32'd0);
        reset = 1'b1;
        repeat (40) tick();
        chk("abort_noresume_ab",  32'({enc_a, enc_b}), 32'd0);
        chk("abort_noresume_pos", 32'(position),       32'd0);
        chk("abort_noresume_rdy", 32'(cmd_ready),      32'd1);

        // Forward count=1: A bounces 1,0,1,0,1 then stays high (bounce build),
        // or is clean high for the whole hold (default build).
        do_reset();
        issue(1'b1, 8'd1);
        for (int k = 1; k <= PC; k++) begin
            tick();
`ifdef QUADRATURE_GEN_BOUNCE_EN
            chk("bounce_a", 32'(enc_a), (k == 2 || k == 4) ? 32'd0 : 32'd1);
`else
            chk("clean_a",  32'(enc_a), 32'd1);
`endif
            chk("single_b",   32'(enc_b),    32'd0);
            chk("single_pos", 32'(position), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quadrature_gen.md
QUADRATURE_GEN -- requirements
Module: quadrature_gen

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 16, meaning clocks between consecutive A/B transitions (legal 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on next rising clk).
REQ-004 SHALL have port cmd_valid  input  1  step command offered.
REQ-005 SHALL have port cmd_dir  input  1  1 = forward (A leads B), 0 = reverse (B leads A).
REQ-006 SHALL have port cmd_count  input  8  number of quadrature transitions to emit (0..255).
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port enc_a  output  1  quadrature channel A, registered.
REQ-009 SHALL have port enc_b  output  1  quadrature channel B, registered.
REQ-010 SHALL have port busy  output  1  command in progress.
REQ-011 SHALL have port position  output  8  net transitions emitted since reset, mod 256.

Function
REQ-012 SHALL implement states IDLE, STEP, HOLD; cmd_ready = (state==IDLE); busy = !cmd_ready.
REQ-013 SHALL accept a command on a clk edge where cmd_valid && cmd_ready; cmd_dir and cmd_count captured at that edge; inputs ignored otherwise.
REQ-014 SHALL, on acceptance with cmd_count==0, stay in IDLE with no transition and no position change.
REQ-015 SHALL, on acceptance with cmd_count>0, enter STEP and emit the first transition on enc_a/enc_b at the next edge (1-cycle latency from acceptance).
REQ-016 SHALL cycle forward as (a,b) 00->10->11->01->00 and reverse as 00->01->11->10->00, continuing from the current (a,b) state; exactly one line changes per transition.
REQ-017 SHALL hold each (a,b) state stable for exactly PHASE_CYCLES clocks before the next transition (HOLD state, counter width ceil(log2(PHASE_CYCLES+1))).
REQ-018 SHALL, after the final transition, hold PHASE_CYCLES clocks, then return to IDLE with cmd_ready=1; back-to-back commands therefore keep PHASE_CYCLES minimum spacing across command boundaries.
REQ-019 SHALL increment position by 1 on each forward transition and decrement by 1 on each reverse transition, in the same cycle enc_a/enc_b change, wrapping 255->0 and 0->255.
REQ-020 SHALL make a new command with opposite cmd_dir reverse direction from the current (a,b) state without any extra or skipped state.

Reset
REQ-021 SHALL, while reset==0 at a clk edge, set state=IDLE, enc_a=0, enc_b=0, position=0, hold counter=0, remaining count=0; cmd_ready=1, busy=0 after that edge.
REQ-022 SHALL, on reset mid-command, abort immediately; the aborted command is discarded and not resumed.

Configuration
REQ-023 SHALL support macro QUADRATURE_GEN_BOUNCE_EN; defined: each transition makes the changing line follow new,old,new,old,new over 5 consecutive clocks, then stay new for the rest of the PHASE_CYCLES hold (PHASE_CYCLES legal 8..255); position counts each transition once, at its first cycle.
REQ-024 SHALL, without QUADRATURE_GEN_BOUNCE_EN, produce clean single-edge transitions with no bounce logic synthesized.

Verification
REQ-025 SHALL cover: reset, cmd forward count=4 PHASE_CYCLES=16 -> (a,b) 10,11,01,00 at 16-cycle spacing, first 1 cycle after accept, position=4, cmd_ready high 16 cycles after last edge.
REQ-026 SHALL cover: from reset, reverse count=1 -> (a,b)=01, position=255 (wrap).
REQ-027 SHALL cover: forward count=2 then reverse count=2 back-to-back -> 10,11,10,00, position returns to 0, no skipped state.
REQ-028 SHALL cover: count=0 accepted -> no output change, cmd_ready stays 1, position unchanged.
REQ-029 SHALL cover: reset==0 asserted during 3rd hold of forward count=8 -> next edge enc_a=enc_b=0, position=0, cmd_ready=1.
REQ-030 SHALL cover: with QUADRATURE_GEN_BOUNCE_EN, forward count=1 -> enc_a 1,0,1,0,1 on 5 consecutive cycles then stable, position=1; decoded by debounce + encoder chain yields one count.
